// File: rtl/sram_bank_sequencer_if.sv
// Request/response channel between the datapath controller and the SRAM bank sequencer.
//   master : requester. It drives req_* and receives req_ready plus the rsp_valid, wr_done and abort pulses.
//   slave  : sequencer. It receives req_* and drives req_ready and the response signals.
interface sram_bank_sequencer_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr_a;
    logic [ADDR_W-1:0] req_addr_b;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data_a;
    logic [DATA_W-1:0] rsp_data_b;
    logic              wr_done;
    logic              abort;

    modport master (
        output req_valid, req_write, req_addr_a, req_addr_b, req_wdata,
        input  req_ready, rsp_valid, rsp_data_a, rsp_data_b, wr_done, abort
    );

    modport slave (
        input  req_valid, req_write, req_addr_a, req_addr_b, req_wdata,
        output req_ready, rsp_valid, rsp_data_a, rsp_data_b, wr_done, abort
    );
endinterface

// File: rtl/sram_bank_sequencer.sv
// Initiator-side controller for the 2-port SRAM register bank.
// It accepts read and write requests on a valid/ready channel. It drives the bank address, data, ReadEn and
// WriteEn on the rising edges of the Bennett phase vector. It returns the bank port A/B read data.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   clkpos            : Bennett positive phase vector
//   bus (slave)       : request channel and response pulses (rsp_valid, wr_done, abort)
//   addr_a, addr_b    : bank Addr_A / Addr_B
//   wdata             : bank write data
//   read_en, write_en : bank ReadEn / WriteEn
//   out_a, out_b      : bank read data
module sram_bank_sequencer #(
    parameter int unsigned PHASES      = 10,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_PH     = 2,
    parameter int unsigned DATA_PH     = 4,
    parameter int unsigned RD_START_PH = 6,
    parameter int unsigned RD_END_PH   = 8,
    parameter int unsigned WR_START_PH = 8,
    parameter int unsigned WR_END_PH   = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PHASES-1:0]    clkpos,
    sram_bank_sequencer_if.slave bus,
    output logic [ADDR_W-1:0]    addr_a,
    output logic [ADDR_W-1:0]    addr_b,
    output logic [DATA_W-1:0]    wdata,
    output logic                 read_en,
    output logic                 write_en,
    input  logic [DATA_W-1:0]    out_a,
    input  logic [DATA_W-1:0]    out_b
);
    typedef enum logic [2:0] {
        IDLE,
        W_DATA,
        W_EN,
        W_HOLD,
        R_WAIT,
        R_EN
    } state_t;

    state_t            state_q;
    logic [PHASES-1:0] prev_q;
    logic [PHASES-1:0] rise;
    logic [DATA_W-1:0] wdata_lat_q;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_data_a_q;
    logic [DATA_W-1:0] rsp_data_b_q;
    logic              read_en_q;
    logic              write_en_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              wr_done_q;
    logic              abort_q;

    // Phase rise detection against the previous cycle's phase vector.
    assign rise = clkpos & ~prev_q;

    // Phases that play no part in sequencing are still edge-detected; this sink only marks them as intentionally unused.
    logic unused_rise;
    assign unused_rise = ^rise;

    // Sequencer FSM with registered bank controls and response pulses.
    always_ff @(posedge clk) begin
        // prev_q also follows clkpos during reset, so no rise is seen on the first cycle after reset.
        prev_q <= clkpos;
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            wdata_lat_q  <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            wdata_q      <= '0;
            rsp_data_a_q <= '0;
            rsp_data_b_q <= '0;
            read_en_q    <= 1'b0;
            write_en_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            wr_done_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
            abort_q     <= 1'b0;

            // A new Bennett cycle started before completion: abandon the transaction and do not take a request.
            if (state_q != IDLE && rise[ADDR_PH]) begin
                read_en_q   <= 1'b0;
                write_en_q  <= 1'b0;
                abort_q     <= 1'b1;
                state_q     <= IDLE;
                req_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.req_valid && rise[ADDR_PH]) begin
                            addr_a_q    <= bus.req_addr_a;
                            addr_b_q    <= bus.req_addr_b;
                            wdata_lat_q <= bus.req_wdata;
                            req_ready_q <= 1'b0;
                            state_q     <= bus.req_write ? W_DATA : R_WAIT;
                        end
                    end
                    W_DATA: begin
                        if (rise[DATA_PH]) begin
                            wdata_q <= wdata_lat_q;
                            state_q <= W_EN;
                        end
                    end
                    W_EN: begin
                        if (rise[WR_START_PH]) begin
                            write_en_q <= 1'b1;
                            state_q    <= W_HOLD;
                        end
                    end
                    W_HOLD: begin
                        if (rise[WR_END_PH]) begin
                            write_en_q  <= 1'b0;
                            wr_done_q   <= 1'b1;
                            req_ready_q <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    R_WAIT: begin
                        if (rise[RD_START_PH]) begin
                            read_en_q <= 1'b1;
                            state_q   <= R_EN;
                        end
                    end
                    R_EN: begin
                        if (rise[RD_END_PH]) begin
                            rsp_data_a_q <= out_a;
                            rsp_data_b_q <= out_b;
                            read_en_q    <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            req_ready_q  <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                    default: begin
                        read_en_q   <= 1'b0;
                        write_en_q  <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                endcase
            end
        end
    end

    assign addr_a         = addr_a_q;
    assign addr_b         = addr_b_q;
    assign wdata          = wdata_q;
    assign read_en        = read_en_q;
    assign write_en       = write_en_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data_a = rsp_data_a_q;
    assign bus.rsp_data_b = rsp_data_b_q;
    assign bus.wr_done    = wr_done_q;
    assign bus.abort      = abort_q;
endmodule

// File: tb/tb_sram_bank_sequencer.sv
// Self-checking bench for sram_bank_sequencer. It drives Bennett phase sequences with random hold lengths,
// random requests, early restarts and resets. It checks every cycle against a transaction-level model and a
// reference memory.
module tb_sram_bank_sequencer;
    localparam int PHASES      = 10;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 16;
    localparam int ADDR_PH     = 2;
    localparam int DATA_PH     = 4;
    localparam int RD_START_PH = 6;
    localparam int RD_END_PH   = 8;
    localparam int WR_START_PH = 8;
    localparam int WR_END_PH   = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              bank_clear;
    logic [PHASES-1:0] clkpos;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata, out_a, out_b;
    logic              read_en, write_en;

    sram_bank_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    sram_bank_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .clkpos   (clkpos),
        .bus      (bus_if),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .wdata    (wdata),
        .read_en  (read_en),
        .write_en (write_en),
        .out_a    (out_a),
        .out_b    (out_b)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return 16'(i * 16'h0501 + 16'h003C);
    endfunction

    // Simple bank: it writes while WriteEn is high and reads combinationally.
    logic [DATA_W-1:0] mem [32];
    always @(posedge clk) begin
        if (bank_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
        end else if (write_en) begin
            mem[addr_a] <= wdata;
        end
    end
    assign out_a = mem[addr_a];
    assign out_b = mem[addr_b];

    typedef struct {
        bit                wr;
        bit                late;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [DATA_W-1:0] d;
    } txn_t;

    txn_t              req_q[$];
    txn_t              cur;
    logic [DATA_W-1:0] ref_mem [32];
    bit                inflight, presented;
    bit                e_we, e_re, e_done, e_rsp, e_abort;
    logic [ADDR_W-1:0] e_addr_a, e_addr_b;
    logic [DATA_W-1:0] e_wdata, e_rsp_a, e_rsp_b;
    int                n_tests, n_fail, cyc_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PHASES-1:0] pat(input int t);
        logic [PHASES-1:0] p = '0;
        for (int k = 0; k < PHASES; k++)
            if ((t < PHASES && k <= t) || (t >= PHASES && k < 2*PHASES-1-t)) p[k] = 1'b1;
        return p;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, " req_ready"}, 32'(bus_if.req_ready), 32'(!inflight));
        check({tag, " write_en"},  32'(write_en),         32'(e_we));
        check({tag, " read_en"},   32'(read_en),          32'(e_re));
        check({tag, " addr_a"},    32'(addr_a),           32'(e_addr_a));
        check({tag, " addr_b"},    32'(addr_b),           32'(e_addr_b));
        check({tag, " wdata"},     32'(wdata),            32'(e_wdata));
        check({tag, " wr_done"},   32'(bus_if.wr_done),   32'(e_done));
        check({tag, " rsp_valid"}, 32'(bus_if.rsp_valid), 32'(e_rsp));
        check({tag, " abort"},     32'(bus_if.abort),     32'(e_abort));
        if (e_rsp) begin
            check({tag, " rsp_data_a"}, 32'(bus_if.rsp_data_a), 32'(e_rsp_a));
            check({tag, " rsp_data_b"}, 32'(bus_if.rsp_data_b), 32'(e_rsp_b));
        end
    endtask

    // Transaction-level expectation update for a rise of phase p (-1: no rise).
    task automatic model_rise(input int p);
        e_done  = 1'b0;
        e_rsp   = 1'b0;
        e_abort = 1'b0;
        if (p == ADDR_PH) begin
            if (inflight) begin
                inflight = 1'b0;
                e_we     = 1'b0;
                e_re     = 1'b0;
                e_abort  = 1'b1;
            end else if (presented) begin
                cur              = req_q.pop_front();
                presented        = 1'b0;
                bus_if.req_valid = 1'b0;
                inflight         = 1'b1;
                e_addr_a         = cur.a;
                e_addr_b         = cur.b;
            end
        end else if (inflight) begin
            if (cur.wr) begin
                if (p == DATA_PH) e_wdata = cur.d;
                if (p == WR_START_PH) begin
                    e_we = 1'b1;
                    ref_mem[cur.a] = cur.d;
                end
                if (p == WR_END_PH) begin
                    e_we     = 1'b0;
                    e_done   = 1'b1;
                    inflight = 1'b0;
                end
            end else begin
                if (p == RD_START_PH) e_re = 1'b1;
                if (p == RD_END_PH) begin
                    e_re     = 1'b0;
                    e_rsp    = 1'b1;
                    e_rsp_a  = ref_mem[cur.a];
                    e_rsp_b  = ref_mem[cur.b];
                    inflight = 1'b0;
                end
            end
        end
    endtask

    task automatic present_if_due();
        if (!presented && req_q.size() > 0 && (!req_q[0].late || cyc_t > ADDR_PH)) begin
            bus_if.req_valid  = 1'b1;
            bus_if.req_write  = req_q[0].wr;
            bus_if.req_addr_a = req_q[0].a;
            bus_if.req_addr_b = req_q[0].b;
            bus_if.req_wdata  = req_q[0].d;
            presented         = 1'b1;
        end
    endtask

    task automatic step(input logic [PHASES-1:0] p_vec, input int p);
        present_if_due();
        clkpos = p_vec;
        @(posedge clk); #1;
        model_rise(p);
        compare_all("rise");
        repeat ($urandom_range(0, 2)) begin
            e_done  = 1'b0;
            e_rsp   = 1'b0;
            e_abort = 1'b0;
            @(posedge clk); #1;
            compare_all("hold");
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        inflight = 1'b0;
        e_we     = 1'b0;
        e_re     = 1'b0;
        e_done   = 1'b0;
        e_rsp    = 1'b0;
        e_abort  = 1'b0;
        e_addr_a = '0;
        e_addr_b = '0;
        e_wdata  = '0;
        compare_all("reset");
    endtask

    task automatic push(input bit wr, input bit late, input int a, input int b, input int d);
        txn_t t;
        t.wr   = wr;
        t.late = late;
        t.a    = 5'(a);
        t.b    = 5'(b);
        t.d    = 16'(d);
        req_q.push_back(t);
    endtask

    // One Bennett cycle; optionally restart it early (abort) or pulse reset after a given step.
    task automatic run_cycle(input int abort_at, input int reset_at);
        bit aborted;
        bit did_reset;
        int t;
        aborted   = 1'b0;
        did_reset = 1'b0;
        t         = 0;
        while (t < 2*PHASES) begin
            cyc_t = t;
            step(pat(t), (t < PHASES) ? t : -1);
            if (t == reset_at && !did_reset) begin
                did_reset = 1'b1;
                do_reset();
            end
            if (t == abort_at && !aborted) begin
                aborted = 1'b1;
                step('0, -1);
                t = 0;
            end else begin
                t++;
            end
        end
    endtask

    initial begin
        int ab, rs;
        n_tests           = 0;
        n_fail            = 0;
        cyc_t             = 0;
        reset             = 1'b1;
        bank_clear        = 1'b1;
        clkpos            = '0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_write  = 1'b0;
        bus_if.req_addr_a = '0;
        bus_if.req_addr_b = '0;
        bus_if.req_wdata  = '0;
        presented         = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        bank_clear = 1'b0;
        do_reset();
        check("reset rsp_data_a", 32'(bus_if.rsp_data_a), 32'h0);
        check("reset rsp_data_b", 32'(bus_if.rsp_data_b), 32'h0);

        // Directed write of 0xAAAA to address 1.
        push(1, 0, 1, 0, 16'hAAAA);
        run_cycle(-1, -1);

        // Directed read of addresses 1 and 2.
        push(1, 0, 2, 0, 16'h1234);
        run_cycle(-1, -1);
        push(0, 0, 1, 2, 0);
        run_cycle(-1, -1);
        check("read rsp_data_a", 32'(bus_if.rsp_data_a), 32'hAAAA);
        check("read rsp_data_b", 32'(bus_if.rsp_data_b), 32'h1234);

        // Late request: presented after the phase-2 rise and taken on the next Bennett cycle.
        push(0, 1, 2, 1, 0);
        run_cycle(-1, -1);
        run_cycle(-1, -1);

        // Abort: restart at phase 2 before ReadEn, while a second request is already held.
        push(0, 0, 5, 6, 0);
        push(0, 0, 7, 8, 0);
        run_cycle(4, -1);
        run_cycle(-1, -1);

        // Reset while WriteEn is high.
        push(1, 0, 9, 10, 16'h5A5A);
        run_cycle(-1, 8);

        // Back-to-back write then read of address 3.
        push(1, 0, 3, 4, 16'h00FF);
        push(0, 0, 3, 0, 0);
        run_cycle(-1, -1);
        run_cycle(-1, -1);
        check("b2b rsp_data_a", 32'(bus_if.rsp_data_a), 32'h00FF);

        // Random traffic with occasional early restarts and resets.
        repeat (60) begin
            if ($urandom_range(0, 3) != 0)
                push(bit'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)));
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 9)) : -1;
            rs = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 19)) : -1;
            run_cycle(ab, rs);
        end
        while (req_q.size() > 0 || inflight) run_cycle(-1, -1);
        run_cycle(-1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
